// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file/immediate operand bundle, optional writeback bypass (OPERAND_FETCH_BYPASS_EN).
// Latency 1 edge; in_ready = (~out_valid | out_ready) & ~flush, so the stage stalls when the bundle is held.
// Backpressure: out_ready=0 freezes the bundle; flush drops it and blocks acceptance that cycle.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [3:0]  r0addr,
  output logic [3:0]  r1addr,
  input  logic [31:0] r0data,
  input  logic [31:0] r1data,
  input  logic        wb_wena,
  input  logic [3:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op0,
  output logic [31:0] out_op1,
  output logic [3:0]  out_rd,
  output logic [31:0] out_instr
);

  logic        imm_sel;
  logic [4:0]  rot_amt;
  logic [63:0] imm_dbl;
  logic [31:0] imm_val;
  logic        hit0;
  logic        hit1;
  logic [31:0] op0_nxt;
  logic [31:0] op1_nxt;
  logic        xfer;

  assign r0addr  = in_instr[19:16];
  assign r1addr  = in_instr[3:0];
  assign imm_sel = in_instr[25];

  // Rotate-right by 2*rot: shift a doubled copy so bits shifted out reappear at the top.
  assign rot_amt = {in_instr[11:8], 1'b0};
  assign imm_dbl = {24'h0, in_instr[7:0], 24'h0, in_instr[7:0]} >> rot_amt;
  assign imm_val = imm_dbl[31:0];

`ifdef OPERAND_FETCH_BYPASS_EN
  assign hit0 = wb_wena && (wb_waddr == r0addr);
  assign hit1 = wb_wena && (wb_waddr == r1addr);
`else
  // Write hazards are resolved downstream; the write port is kept only for pin compatibility.
  logic unused_wb;
  assign unused_wb = ^{wb_wena, wb_waddr};
  assign hit0 = 1'b0;
  assign hit1 = 1'b0;
`endif

  assign op0_nxt = hit0 ? wb_wdata : r0data;
  assign op1_nxt = imm_sel ? imm_val : (hit1 ? wb_wdata : r1data);

  assign in_ready = (~out_valid | out_ready) & ~flush;
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op0   <= 32'h0;
      out_op1   <= 32'h0;
      out_rd    <= 4'h0;
      out_instr <= 32'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_op0   <= op0_nxt;
      out_op1   <= op1_nxt;
      out_rd    <= in_instr[15:12];
      out_instr <= in_instr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 The block SHALL have reset (input, 1): asynchronous, active-high.
REQ-003 in_valid  input  1  instruction word present on in_instr.
REQ-004 in_instr  input  32  ARM data-processing instruction: Rn=[19:16], Rd=[15:12], rot=[11:8], imm8=[7:0], Rm=[3:0], I=[25].
REQ-005 in_ready  output  1  block accepts in_instr this cycle.
REQ-006 r0addr, r1addr  output  4 each  read addresses driven to the 16x32 register file.
REQ-007 r0data, r1data  input  32 each  register file read data, combinational from r0addr/r1addr.
REQ-008 wb_wena, wb_waddr, wb_wdata  input  1/4/32  the register file write port, sampled for bypass.
REQ-009 flush  input  1  discard the held operand bundle.
REQ-010 out_valid  output  1  operand bundle valid.
REQ-011 out_ready  input  1  downstream consumes the bundle.
REQ-012 out_op0, out_op1  output  32 each  registered operands.
REQ-013 out_rd, out_instr  output  4/32  registered destination index and instruction.

Function
REQ-014 r0addr SHALL equal in_instr[19:16] and r1addr SHALL equal in_instr[3:0], combinationally, regardless of in_valid.
REQ-015 in_ready SHALL equal (~out_valid | out_ready) & ~flush.
REQ-016 A transfer SHALL occur on a rising edge where in_valid & in_ready; then out_op0, out_op1, out_rd=in_instr[15:12] and out_instr=in_instr are loaded and out_valid is set to 1.
REQ-017 op0 source: r0data, or wb_wdata when bypass hits (REQ-022).
REQ-018 op1 source when I=0: r1data, or wb_wdata when bypass hits; when I=1: {24'h0, imm8} rotated right by 2*rot (rot=0 gives no rotation; all 32-bit, wrap-around of bits).
REQ-019 With out_valid=1, out_ready=1 and no new transfer, out_valid SHALL clear on the next edge; with out_ready=0, all out_* registers SHALL hold unchanged (stall).
REQ-020 Simultaneous consume and accept (out_valid, out_ready, in_valid all 1) SHALL load the new bundle with out_valid remaining 1: zero-bubble throughput of one instruction per cycle.
REQ-021 flush=1 SHALL clear out_valid on the next edge and block any transfer that cycle; flush takes priority over all other events; out_op*/out_rd/out_instr values are don't-care after flush.
REQ-022 Bypass hit for a port: wb_wena=1 and wb_waddr equals that port's read address in the same cycle as the transfer; latency from in_instr to out_op* is exactly one edge.

Reset
REQ-023 reset=1 SHALL asynchronously force out_valid=0, out_op0=0, out_op1=0, out_rd=0, out_instr=0.
REQ-024 Reset asserted mid-stall SHALL discard the held bundle; after deassertion in_ready=1 on the first cycle.

Configuration
REQ-025 Macro OPERAND_FETCH_BYPASS_EN defined: REQ-017/018/022 bypass is active.
REQ-026 Macro OPERAND_FETCH_BYPASS_EN undefined: wb_* ports SHALL remain present but are ignored; operands come only from r0data/r1data/immediate, and the consumer resolves same-cycle write hazards.

Verification
REQ-027 Reset held 100 ns then released -> all out_* = 0, out_valid=0, in_ready=1.
REQ-028 RF R1=0x11111111, R2=0x22222222; instr 0xE0813002 (ADD R3,R1,R2), out_ready=1 -> next edge out_op0=0x11111111, out_op1=0x22222222, out_rd=3, out_valid=1.
REQ-029 Instr 0xE2814CFF (I=1, rot=0xC, imm8=0xFF) -> out_op1=0x0000FF00.
REQ-030 With bypass enabled, same cycle wb_wena=1, wb_waddr=1, wb_wdata=0x88887777 during REQ-028 instr -> out_op0=0x88887777; macro undefined -> out_op0=0x11111111.
REQ-031 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 then -> next instruction loaded with no bubble.
REQ-032 flush=1 with out_valid=1 and in_valid=1 -> next edge out_valid=0, no instruction accepted that cycle.
